// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter: serialises N requesters onto the RAM data port
// with fixed or round-robin priority, channel-0 lock and a mem_ready timeout abort.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  input  logic                        lock,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                        busy,
  output logic [NUM_REQ-1:0]          stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int unsigned GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;

  // Arbitration: round-robin scans upward from the channel after the last grant.
  always_comb begin
    elig  = lock ? (req & NUM_REQ'(1)) : req;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    if (RR_MODE != 0) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = GW'((32'(last_q) + k) % NUM_REQ);
        if (!found && elig[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = GW'(k);
        if (!found && elig[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = pick;
          mem_we_d    = we[pick];
          mem_addr_d  = addr[32'(pick) * ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[32'(pick) * DATA_W +: DATA_W];
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (RR_MODE != 0) last_d = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == S_RESP) ack[grant_q] = 1'b1;
    err       = (state_q == S_RESP) && err_q;
    busy      = (state_q != S_IDLE);
    mem_req   = (state_q == S_ISSUE);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    rdata     = rdata_q;
    grant_id  = grant_q;
    stall     = req & ~ack;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-requester arbiter for the shared single-port data memory.
- Successor to the hard-wired two-way FPGA/CPU address, data and write-enable muxing.
- Serialises loader, CPU and debug accesses through a request/acknowledge handshake, with fixed or round-robin priority, an exclusive-lock mode for channel 0, and a memory-timeout abort.
- Sits between the requesters and the RAM data port.

Parameters:
NUM_REQ, 2, number of requester channels (2..8); channel 0 is the loader/FPGA channel.
ADDR_W, 12, memory address width.
DATA_W, 32, data width.
RR_MODE, 1, 1 = round-robin priority, 0 = fixed priority (lowest index wins).
TIMEOUT, 255, maximum cycles to wait for mem_ready before abort (1..2^16-1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-channel request.
- we  in  NUM_REQ  per-channel write (1) / read (0).
- addr  in  NUM_REQ*ADDR_W  flattened; channel i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened; channel i at [i*DATA_W +: DATA_W].
- lock  in  1  when high, only channel 0 may be granted.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted channel.
- err  out  1  high with ack when the transaction timed out.
- rdata  out  DATA_W  read data, valid in the ack cycle, held until the next completion.
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current/last granted channel.
- busy  out  1  high in ISSUE and RESP.
- stall  out  NUM_REQ  stall[i] = req[i] & ~ack[i] (combinational).
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Reset values:
  - state = IDLE; ack = 0, err = 0, rdata = 0, grant_id = 0, busy = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Round-robin pointer last = NUM_REQ-1, so channel 0 has first priority.
  - Timeout counter = 0.
  - Reset mid-transaction aborts immediately; no ack is issued.
- State machine IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Eligible set E = req, or req & 1 when lock=1.
  - If E != 0: choose g.
    - RR_MODE=1: first set bit scanning from last+1, wrapping modulo NUM_REQ.
    - RR_MODE=0: lowest set index.
  - Register grant_id = g; mem_addr, mem_wdata, mem_we from channel g; mem_req = 1; counter = 0; go ISSUE.
  - If E = 0: stay IDLE; mem outputs hold their last values with mem_req = 0.
- ISSUE:
  - mem_* outputs are stable for the whole state.
  - If mem_ready = 1: rdata = mem_rdata (reads only; writes leave rdata unchanged); mem_req = 0; err = 0; go RESP.
  - Else if counter == TIMEOUT-1: mem_req = 0; err = 1; rdata unchanged; go RESP.
  - Else: counter + 1.
- RESP:
  - ack[grant_id] = 1 for exactly this cycle; err is valid this cycle only.
  - In RR_MODE, last = grant_id.
  - Return to IDLE; req is ignored in this cycle.
- Latency:
  - req sampled at edge t gives mem_req high from t+1.
  - mem_ready in cycle t+1 gives ack in cycle t+2.
  - Minimum 3 cycles per transaction.
- Handshake:
  - A requester holds req, we, addr and wdata stable until ack.
  - req still high in the cycle after ack is a new transaction, arbitrated normally.
  - Dropping req before ack is illegal; the transaction still completes and ack is still pulsed.
- lock:
  - Evaluated only in IDLE.
  - Asserting lock during another channel's transaction lets that transaction finish.
  - Non-zero channels then stall until lock = 0.
- Simultaneous requests:
  - Exactly one grant per arbitration.
  - Under round-robin, no channel waits more than NUM_REQ-1 transactions while requesting continuously.
- mem_ready outside ISSUE is ignored.
- Counter width is 16 bits; no wrap occurs because the abort fires at TIMEOUT-1.

Test Plan:
1. Single read: ch1 req, we=0, addr=0x010; memory returns 0xDEADBEEF with mem_ready in the first ISSUE cycle -> mem_addr=0x010 and mem_we=0 at t+1; ack=2'b10 and rdata=0xDEADBEEF at t+2; err=0.
2. Round-robin contention (RR_MODE=1, NUM_REQ=3): ch0, ch1, ch2 hold req continuously, zero-wait memory -> grant_id sequence 0,1,2,0; each ack 3 cycles apart.
3. Fixed priority (RR_MODE=0): ch0 and ch1 both request continuously -> ch0 granted every transaction; ch1 stall stays 1.
4. Lock:
   - ch1 transaction in flight, lock raised -> ch1 completes and acks.
   - ch1 re-requests -> not granted while ch0 writes 0x00000042 to addr 0x020.
   - lock drops -> ch1 granted at the next IDLE.
5. Timeout (TIMEOUT=4): mem_ready held 0 -> mem_req high exactly 4 cycles; ack plus err=1 in the next cycle; rdata unchanged.
6. Reset mid-op: rst=1 in the second ISSUE cycle -> next cycle mem_req=0, ack=0, busy=0, grant_id=0; after release, ch0 and ch1 requesting together -> ch0 granted first.
